// File: rtl/seg7_scan_display.sv
// seg7_scan_display: double-buffered multiplexed 7-segment BCD scanner (optional blink via SEG7_BLINK_EN)
module seg7_scan_display #(
  parameter int DIGITS = 4,
  parameter int REFRESH_DIV = 1500,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
`ifdef SEG7_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_tick
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 7'h7F : 7'h00;
  localparam logic DP_OFF = SEG_ACTIVE_LOW != 0;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] pend_din, act_din;
  logic [DIGITS-1:0]   pend_dp, act_dp, lz;
  logic                pend_flag, wrap, boundary, zero_above, dark, off;
  logic [3:0]          cur;
  logic [6:0]          glyph;
  assign wrap = cnt == CW'(REFRESH_DIV - 1);
  assign boundary = wrap && idx == IW'(DIGITS - 1);
  assign cur = act_din[4*idx +: 4];
  // Prescaler and slot index; the index wraps explicitly so DIGITS need not be a power of two
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= boundary ? '0 : idx + 1'b1;
    end
  // Double buffer: values reach the active set only at a frame boundary; a load on the boundary bypasses pending
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pend_din <= '0;
      pend_dp <= '0;
      act_din <= '0;
      act_dp <= '0;
      pend_flag <= 1'b0;
    end else if (boundary) begin
      act_din <= load ? din : pend_flag ? pend_din : act_din;
      act_dp <= load ? dp_in : pend_flag ? pend_dp : act_dp;
      pend_flag <= 1'b0;
    end else if (load) begin
      pend_din <= din;
      pend_dp <= dp_in;
      pend_flag <= 1'b1;
    end
  // BCD to segment glyph, codes above 9 render as a dash
  always_comb
    case (cur)
      4'd0: glyph = 7'h3F;
      4'd1: glyph = 7'h06;
      4'd2: glyph = 7'h5B;
      4'd3: glyph = 7'h4F;
      4'd4: glyph = 7'h66;
      4'd5: glyph = 7'h6D;
      4'd6: glyph = 7'h7D;
      4'd7: glyph = 7'h07;
      4'd8: glyph = 7'h7F;
      4'd9: glyph = 7'h6F;
      default: glyph = 7'h40;
    endcase
  // Leading-zero mask: digit k is a leading zero when it and all digits above it are zero; digit 0 never is
  always_comb begin
    zero_above = 1'b1;
    lz = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above && act_din[4*k +: 4] == 4'd0;
      lz[k] = zero_above;
    end
  end
`ifdef SEG7_BLINK_EN
  logic [7:0] fcnt;
  // Frame counter; its MSB gives the blink half-period of 128 frames
  always_ff @(posedge clk or negedge reset)
    if (!reset) fcnt <= '0;
    else if (boundary) fcnt <= fcnt + 1'b1;
  assign dark = fcnt[7] && blink_mask[idx];
`else
  assign dark = 1'b0;
`endif
  assign off = dark || (blank_lz && lz[idx]);
  // Registered outputs for the current slot; XOR with the off pattern handles panel polarity
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      seg_out <= SEG_OFF;
      dp_out <= DP_OFF;
      dig_sel <= '0;
      frame_tick <= 1'b0;
    end else begin
      seg_out <= (off ? 7'h00 : glyph) ^ SEG_OFF;
      dp_out <= (act_dp[idx] && !dark) ^ DP_OFF;
      dig_sel <= DIGITS'(1) << idx;
      frame_tick <= boundary;
    end
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed checks of scanning, double buffering, blanking and polarity
module tb_seg7_scan_display;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load = 1'b0;
  logic [15:0] din = '0;
  logic [3:0] dp_in = '0;
  logic blank_lz = 1'b0;
  logic [6:0] seg0, seg1;
  logic dp0, dp1, tick0, tick1;
  logic [3:0] sel0, sel1;
  int total = 0;
  int passes = 0;
  seg7_scan_display #(.DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0)) u0 (
    .clk(clk), .reset(reset), .load(load), .din(din), .dp_in(dp_in), .blank_lz(blank_lz),
    .seg_out(seg0), .dp_out(dp0), .dig_sel(sel0), .frame_tick(tick0));
  seg7_scan_display #(.DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1)) u1 (
    .clk(clk), .reset(reset), .load(load), .din(din), .dp_in(dp_in), .blank_lz(blank_lz),
    .seg_out(seg1), .dp_out(dp1), .dig_sel(sel1), .frame_tick(tick1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic chk_reset();
    chk("rst_sel", {4'h0, sel0}, 8'h00);
    chk("rst_tick", {7'h0, tick0}, 8'h00);
    chk("rst_seg", {1'b0, seg0}, 8'h00);
    chk("rst_dp", {7'h0, dp0}, 8'h00);
    chk("rst_seg_n", {1'b0, seg1}, 8'h7F);
    chk("rst_dp_n", {7'h0, dp1}, 8'h01);
    chk("rst_sel_n", {4'h0, sel1}, 8'h00);
  endtask
  // One full frame of 16 cycles; es packs slot glyphs {s3,s2,s1,s0}; optional load pulse at cycle li
  task automatic check_slots(input logic [27:0] es, input logic [3:0] ed, input int li,
                             input logic [15:0] ld, input logic [3:0] lp);
    int s;
    logic [3:0] es_sel;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == li) begin
        load = 1'b1;
        din = ld;
        dp_in = lp;
      end else load = 1'b0;
      s = i / 4;
      es_sel = 4'b0001 << s;
      chk($sformatf("sel[%0d]", i), {4'h0, sel0}, {4'h0, es_sel});
      chk($sformatf("tick[%0d]", i), {7'h0, tick0}, {7'h0, i == 15});
      chk($sformatf("seg[%0d]", i), {1'b0, seg0}, {1'b0, es[7*s +: 7]});
      chk($sformatf("dp[%0d]", i), {7'h0, dp0}, {7'h0, ed[s]});
      chk($sformatf("seg_n[%0d]", i), {1'b0, seg1}, {1'b0, ~es[7*s +: 7]});
      chk($sformatf("dp_n[%0d]", i), {7'h0, dp1}, {7'h0, ~ed[s]});
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    #22;
    chk_reset();
    @(negedge clk);
    reset = 1'b1;
    check_slots({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, -1, 16'h0, 4'h0);
    check_slots({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, -1, 16'h0, 4'h0);
    check_slots({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, 0, 16'h1234, 4'h0);
    check_slots({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000, -1, 16'h0, 4'h0);
    blank_lz = 1'b1;
    check_slots({7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000, 3, 16'h0070, 4'h0);
    check_slots({7'h00, 7'h00, 7'h07, 7'h3F}, 4'b0000, -1, 16'h0, 4'h0);
    blank_lz = 1'b0;
    check_slots({7'h3F, 7'h3F, 7'h07, 7'h3F}, 4'b0000, -1, 16'h0, 4'h0);
    load = 1'b1;
    din = 16'h00A5;
    check_slots({7'h3F, 7'h3F, 7'h07, 7'h3F}, 4'b0000, 6, 16'h0009, 4'h0);
    check_slots({7'h3F, 7'h3F, 7'h3F, 7'h6F}, 4'b0000, -1, 16'h0, 4'h0);
    load = 1'b1;
    din = 16'h1234;
    check_slots({7'h3F, 7'h3F, 7'h3F, 7'h6F}, 4'b0000, 14, 16'h0008, 4'h0);
    check_slots({7'h3F, 7'h3F, 7'h3F, 7'h7F}, 4'b0000, -1, 16'h0, 4'h0);
    check_slots({7'h3F, 7'h3F, 7'h3F, 7'h7F}, 4'b0000, 0, 16'h0005, 4'b0010);
    check_slots({7'h3F, 7'h3F, 7'h3F, 7'h6D}, 4'b0010, -1, 16'h0, 4'h0);
    load = 1'b1;
    din = 16'h0009;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset();
    @(negedge clk);
    chk_reset();
    reset = 1'b1;
    check_slots({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, -1, 16'h0, 4'h0);
    check_slots({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, -1, 16'h0, 4'h0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
